// File: rtl/sps_round_controller.sv
// Initiator side of the stone-paper-scissors judge handshake: collects one sealed move per
// player, runs the start/evaluate/release exchange with the judge and keeps the match score.
module sps_round_controller #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned RND_W      = 6,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1_valid,
    input  logic [1:0]         p1_sel,
    input  logic               p2_valid,
    input  logic [1:0]         p2_sel,
    input  logic               new_match,
    input  logic [1:0]         winner,
    input  logic [2:0]         judge_state,
    output logic [1:0]         p1_move,
    output logic [1:0]         p2_move,
    output logic               start,
    output logic               p1_locked,
    output logic               p2_locked,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [RND_W-1:0]   round_cnt,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               invalid_round,
    output logic               judge_err,
    output logic [1:0]         ctrl_state
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [SCORE_W-1:0] TARGET   = SCORE_W'(WIN_TARGET);
    localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] JUDGE_IDLE = 3'b000;
    localparam logic [2:0] JUDGE_EVAL = 3'b001;

    typedef enum logic [1:0] {
        StCollect = 2'b00,
        StReq     = 2'b01,
        StWaitRel = 2'b10,
        StDone    = 2'b11
    } state_e;

    state_e           state;
    logic [TMR_W-1:0] timer;

    logic timed_out;
    logic p1_at_target;
    logic p2_at_target;

    assign timed_out    = (timer == TMR_LAST);
    assign p1_at_target = (p1_score == TARGET);
    assign p2_at_target = (p2_score == TARGET);
    assign ctrl_state   = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StCollect;
            timer         <= '0;
            p1_move       <= 2'b00;
            p2_move       <= 2'b00;
            start         <= 1'b0;
            p1_locked     <= 1'b0;
            p2_locked     <= 1'b0;
            p1_score      <= '0;
            p2_score      <= '0;
            round_cnt     <= '0;
            match_over    <= 1'b0;
            match_winner  <= 2'b00;
            invalid_round <= 1'b0;
            judge_err     <= 1'b0;
        end else begin
            invalid_round <= 1'b0;
            unique case (state)
                StCollect: begin
                    if (new_match) begin
                        p1_score     <= '0;
                        p2_score     <= '0;
                        round_cnt    <= '0;
                        match_over   <= 1'b0;
                        match_winner <= 2'b00;
                        judge_err    <= 1'b0;
                        p1_locked    <= 1'b0;
                        p2_locked    <= 1'b0;
                        p1_move      <= 2'b00;
                        p2_move      <= 2'b00;
                    end else if (p1_locked && p2_locked) begin
                        state <= StReq;
                        start <= 1'b1;
                        timer <= '0;
                    end else begin
                        // First strobe per player wins; later ones wait for the next round.
                        if (p1_valid && !p1_locked) begin
                            p1_move   <= p1_sel;
                            p1_locked <= 1'b1;
                        end
                        if (p2_valid && !p2_locked) begin
                            p2_move   <= p2_sel;
                            p2_locked <= 1'b1;
                        end
                    end
                end

                StReq: begin
                    if (judge_state == JUDGE_EVAL) begin
                        case (winner)
                            2'b01: begin
                                if (p1_score < TARGET) p1_score <= p1_score + 1'b1;
                                round_cnt <= round_cnt + 1'b1;
                            end
                            2'b10: begin
                                if (p2_score < TARGET) p2_score <= p2_score + 1'b1;
                                round_cnt <= round_cnt + 1'b1;
                            end
                            2'b00:   round_cnt <= round_cnt + 1'b1;
                            default: invalid_round <= 1'b1;
                        endcase
                        start <= 1'b0;
                        state <= StWaitRel;
                        timer <= '0;
                    end else if (timed_out) begin
                        start     <= 1'b0;
                        judge_err <= 1'b1;
                        p1_locked <= 1'b0;
                        p2_locked <= 1'b0;
                        p1_move   <= 2'b00;
                        p2_move   <= 2'b00;
                        state     <= StCollect;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                StWaitRel: begin
                    if (judge_state == JUDGE_IDLE) begin
                        p1_locked <= 1'b0;
                        p2_locked <= 1'b0;
                        p1_move   <= 2'b00;
                        p2_move   <= 2'b00;
                        if (p1_at_target || p2_at_target) begin
                            state        <= StDone;
                            match_over   <= 1'b1;
                            match_winner <= p1_at_target ? 2'b01 : 2'b10;
                        end else begin
                            state <= StCollect;
                        end
                    end else if (timed_out) begin
                        start     <= 1'b0;
                        judge_err <= 1'b1;
                        p1_locked <= 1'b0;
                        p2_locked <= 1'b0;
                        p1_move   <= 2'b00;
                        p2_move   <= 2'b00;
                        state     <= StCollect;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                StDone: begin
                    if (new_match) begin
                        p1_score     <= '0;
                        p2_score     <= '0;
                        round_cnt    <= '0;
                        match_over   <= 1'b0;
                        match_winner <= 2'b00;
                        judge_err    <= 1'b0;
                        state        <= StCollect;
                    end
                end

                default: state <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_sps_round_controller.sv
// Bench for sps_round_controller: a judge model drives the handshake, and a round-level
// reference model predicts every output each cycle under directed and random stimulus.
module tb_sps_round_controller;

    localparam int WT   = 3;
    localparam int SW   = 4;
    localparam int RW   = 6;
    localparam int TO   = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          p1_valid = 1'b0, p2_valid = 1'b0, new_match = 1'b0;
    logic [1:0]    p1_sel = 2'b00, p2_sel = 2'b00;
    logic [1:0]    winner;
    logic [2:0]    judge_state = 3'b000;
    logic [1:0]    p1_move, p2_move, match_winner, ctrl_state;
    logic          start, p1_locked, p2_locked, match_over, invalid_round, judge_err;
    logic [SW-1:0] p1_score, p2_score;
    logic [RW-1:0] round_cnt;

    int errors = 0;
    int checks = 0;
    int jmode  = 0;  // 0 normal judge, 1 judge never leaves IDLE, 2 judge stuck in RESULT

    sps_round_controller #(
        .WIN_TARGET(WT), .SCORE_W(SW), .RND_W(RW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .p1_valid(p1_valid), .p1_sel(p1_sel), .p2_valid(p2_valid), .p2_sel(p2_sel),
        .new_match(new_match), .winner(winner), .judge_state(judge_state),
        .p1_move(p1_move), .p2_move(p2_move), .start(start),
        .p1_locked(p1_locked), .p2_locked(p2_locked),
        .p1_score(p1_score), .p2_score(p2_score), .round_cnt(round_cnt),
        .match_over(match_over), .match_winner(match_winner),
        .invalid_round(invalid_round), .judge_err(judge_err), .ctrl_state(ctrl_state)
    );

    always #5 clk = ~clk;

    // Rules of the game: 3 means invalid, otherwise b beats a when b is one step ahead mod 3.
    function automatic logic [1:0] judge_of(input int a, input int b);
        if (a == 3 || b == 3) return 2'd3;
        if (a == b) return 2'd0;
        if ((a + 1) % 3 == b) return 2'd2;
        return 2'd1;
    endfunction

    assign winner = judge_of(int'(p1_move), int'(p2_move));

    always @(posedge clk) begin
        case (judge_state)
            3'b000:  if (jmode != 1 && start) judge_state <= 3'b001;
            3'b001:  judge_state <= 3'b010;
            3'b010:  if (jmode != 2 && !start) judge_state <= 3'b000;
            default: judge_state <= 3'b000;
        endcase
    end

    // Reference model: phase uses the ctrl_state encoding, age counts edges spent in REQ/WAIT_REL.
    int m_phase, m_age, m_mv1, m_mv2, m_s1, m_s2, m_rc, m_mw;
    bit m_l1, m_l2, m_st, m_mo, m_inv, m_err;

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_mv1 = 0; m_mv2 = 0; m_s1 = 0; m_s2 = 0; m_rc = 0;
        m_mw = 0; m_l1 = 0; m_l2 = 0; m_st = 0; m_mo = 0; m_inv = 0; m_err = 0;
    endtask

    task automatic model_clear_match();
        m_s1 = 0; m_s2 = 0; m_rc = 0; m_mo = 0; m_mw = 0; m_err = 0;
    endtask

    task automatic model_release_round();
        m_l1 = 0; m_l2 = 0; m_mv1 = 0; m_mv2 = 0;
    endtask

    task automatic model_edge();
        int w;
        int js;
        js = int'(judge_state);
        m_inv = 0;
        case (m_phase)
            0: begin
                if (new_match) begin
                    model_clear_match();
                    model_release_round();
                end else if (m_l1 && m_l2) begin
                    m_phase = 1; m_st = 1; m_age = 0;
                end else begin
                    if (p1_valid && !m_l1) begin m_mv1 = int'(p1_sel); m_l1 = 1; end
                    if (p2_valid && !m_l2) begin m_mv2 = int'(p2_sel); m_l2 = 1; end
                end
            end
            1: begin
                if (js == 1) begin
                    w = int'(judge_of(m_mv1, m_mv2));
                    if (w == 3) m_inv = 1;
                    else m_rc = (m_rc + 1) % (1 << RW);
                    if (w == 1 && m_s1 < WT) m_s1++;
                    if (w == 2 && m_s2 < WT) m_s2++;
                    m_st = 0; m_phase = 2; m_age = 0;
                end else if (m_age + 1 == TO) begin
                    m_st = 0; m_err = 1; model_release_round(); m_phase = 0;
                end else m_age++;
            end
            2: begin
                if (js == 0) begin
                    model_release_round();
                    if (m_s1 == WT || m_s2 == WT) begin
                        m_phase = 3; m_mo = 1; m_mw = (m_s1 == WT) ? 1 : 2;
                    end else m_phase = 0;
                end else if (m_age + 1 == TO) begin
                    m_st = 0; m_err = 1; model_release_round(); m_phase = 0;
                end else m_age++;
            end
            default: begin
                if (new_match) begin model_clear_match(); m_phase = 0; end
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        chk("p1_move", int'(p1_move), m_mv1);
        chk("p2_move", int'(p2_move), m_mv2);
        chk("start", int'(start), int'(m_st));
        chk("p1_locked", int'(p1_locked), int'(m_l1));
        chk("p2_locked", int'(p2_locked), int'(m_l2));
        chk("p1_score", int'(p1_score), m_s1);
        chk("p2_score", int'(p2_score), m_s2);
        chk("round_cnt", int'(round_cnt), m_rc);
        chk("match_over", int'(match_over), int'(m_mo));
        chk("match_winner", int'(match_winner), m_mw);
        chk("invalid_round", int'(invalid_round), int'(m_inv));
        chk("judge_err", int'(judge_err), int'(m_err));
        chk("ctrl_state", int'(ctrl_state), m_phase);
    endtask

    // Inputs are set before calling; the model steps on pre-edge values, then outputs are checked.
    task automatic cycle();
        if (reset) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        compare();
        @(negedge clk);
    endtask

    task automatic drive(input bit v1, input logic [1:0] s1, input bit v2, input logic [1:0] s2,
                         input bit nm);
        p1_valid = v1; p1_sel = s1; p2_valid = v2; p2_sel = s2; new_match = nm;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic play_round(input logic [1:0] s1, input logic [1:0] s2);
        drive(1'b1, s1, 1'b1, s2, 1'b0);
        idle(5);
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare();
        chk("async_reset_start", int'(start), 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("reset_ctrl_state", int'(ctrl_state), 0);
        chk("reset_start", int'(start), 0);
        reset = 1'b0;

        // P1 stone vs P2 scissors, strobed together.
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b00, 1'b1, 2'b10, 1'b0);
        chk("lock_both", int'(p1_locked & p2_locked), 1);
        idle(1);
        chk("k1_start", int'(start), 1);
        chk("k1_req", int'(ctrl_state), 1);
        idle(2);
        chk("k3_p1_score", int'(p1_score), 1);
        chk("k3_round_cnt", int'(round_cnt), 1);
        chk("k3_start_low", int'(start), 0);
        idle(2);
        chk("k5_collect", int'(ctrl_state), 0);
        chk("k5_unlocked", int'(p1_locked), 0);

        // First strobe wins; tie of paper vs paper.
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0);
        chk("first_move_kept", int'(p1_move), 1);
        idle(5);
        chk("tie_round_cnt", int'(round_cnt), 1);
        chk("tie_scores", int'(p1_score) + int'(p2_score), 0);

        // Invalid move produces a single-cycle pulse and no count.
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b11, 1'b1, 2'b00, 1'b0);
        idle(3);
        chk("invalid_pulse", int'(invalid_round), 1);
        idle(1);
        chk("invalid_pulse_end", int'(invalid_round), 0);
        idle(1);
        chk("invalid_round_cnt", int'(round_cnt), 0);

        // P2 takes the match 3-0.
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        repeat (3) play_round(2'b00, 2'b01);
        chk("match_done", int'(ctrl_state), 3);
        chk("match_p2_score", int'(p2_score), 3);
        chk("match_winner_p2", int'(match_winner), 2);
        drive(1'b1, 2'b10, 1'b1, 2'b10, 1'b0);
        idle(1);
        chk("done_ignores", int'(p1_locked), 0);
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        chk("new_match_collect", int'(ctrl_state), 0);
        chk("new_match_over", int'(match_over), 0);

        // Judge never answers: abort after TO cycles in REQ.
        jmode = 1;
        drive(1'b1, 2'b00, 1'b1, 2'b00, 1'b0);
        idle(TO);
        chk("to_still_req", int'(ctrl_state), 1);
        idle(1);
        chk("to_judge_err", int'(judge_err), 1);
        chk("to_start_low", int'(start), 0);
        chk("to_unlocked", int'(p2_locked), 0);
        jmode = 0;

        // Reset during a request, then a clean round.
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b01, 1'b1, 2'b01, 1'b0);
        idle(1);
        chk("pre_reset_start", int'(start), 1);
        mid_reset();
        idle(3);
        chk("judge_back_idle", int'(judge_state), 0);
        play_round(2'b00, 2'b10);
        chk("post_reset_round", int'(p1_score), 1);

        // Random play with occasional stalls, match restarts and resets.
        for (int i = 0; i < 4000; i++) begin
            if (jmode != 0) begin
                if ($urandom_range(0, 24) == 0) jmode = 0;
            end else if ($urandom_range(0, 149) == 0) begin
                jmode = int'($urandom_range(1, 2));
            end
            if ($urandom_range(0, 599) == 0) mid_reset();
            drive(1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 79) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sps_round_controller.md
# sps_round_controller

Initiator side of the stone-paper-scissors judge handshake. Collects one sealed move from each player, drives the move pair and `start` to the judge FSM, samples its combinational `winner` during the judge's EVALUATE cycle, releases `start` so the judge returns to IDLE, and keeps a first-to-`WIN_TARGET` match score.

## Interface
- `WIN_TARGET`, default 3: round wins needed to take the match (1..2^SCORE_W-1).
- `SCORE_W`, default 4: width of score counters.
- `RND_W`, default 6: width of the round counter.
- `TIMEOUT`, default 15: max cycles spent in REQ or WAIT_REL before abort.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `p1_valid` in 1: player 1 move strobe, sampled each edge.
- `p1_sel` in 2: player 1 move (00 stone, 01 paper, 10 scissors, 11 passed through unchanged).
- `p2_valid` in 1, `p2_sel` in 2: same for player 2.
- `new_match` in 1: clears scores and round count.
- `winner` in 2: judge result (00 tie, 01 P1, 10 P2, 11 invalid).
- `judge_state` in 3: judge FSM state (000 IDLE, 001 EVALUATE, 010 RESULT).
- `p1_move` out 2, `p2_move` out 2: registered moves to the judge.
- `start` out 1: registered start request to the judge.
- `p1_locked` out 1, `p2_locked` out 1: move accepted for this round.
- `p1_score` out SCORE_W, `p2_score` out SCORE_W: rounds won.
- `round_cnt` out RND_W: decided rounds (ties included, invalid excluded), wraps.
- `match_over` out 1, `match_winner` out 2 (01 P1, 10 P2, 00 none).
- `invalid_round` out 1: one-cycle pulse when judge reports 11.
- `judge_err` out 1: sticky; set on timeout.
- `ctrl_state` out 2: 00 COLLECT, 01 REQ, 10 WAIT_REL, 11 DONE.

## Operation
- Reset: every output 0 / 00, FSM in COLLECT.
- COLLECT: first `pN_valid` per player loads `pN_move <= pN_sel`, sets `pN_locked`. Later strobes are ignored until the round ends. Simultaneous valids lock both. Once both locks are 1 (registered), the next edge goes to REQ with `start <= 1`.
- REQ: `start` stays 1 and the moves are held. At the edge where `judge_state == 001`, capture `winner`:
  - 01: `p1_score++`.
  - 10: `p2_score++`.
  - 00: no score change.
  - 01/10/00: `round_cnt++`.
  - 11: no counter change; `invalid_round` pulses in the following cycle.
  - On the same edge: `start <= 0`, go to WAIT_REL.
- WAIT_REL: `start` = 0. On the edge where `judge_state == 000`:
  - Clear both locks and both moves to 00.
  - If either score equals `WIN_TARGET`: go to DONE, `match_over <= 1`, `match_winner` set.
  - Otherwise go to COLLECT.
- DONE: ignore strobes. `new_match` clears scores, `round_cnt`, `match_over`, `match_winner`, `judge_err`, then returns to COLLECT.
- `new_match` in COLLECT: same clears, plus clears locks. In REQ/WAIT_REL it is ignored; the judge handshake is never aborted by it.
- Timeout: a cycle counter resets on entry to REQ and to WAIT_REL. On reaching `TIMEOUT` in either state:
  - `start <= 0`, `judge_err <= 1`, locks and moves cleared, go to COLLECT.
  - Scores unchanged.
- Scores never exceed `WIN_TARGET`; at most one increments per round.

## Timing
- Both valids at edge k: locks visible after k. Edges:
  - k+1: REQ, `start` = 1.
  - k+2: judge EVALUATE.
  - k+3: winner captured, scores updated, `start` = 0.
  - k+4: judge IDLE.
  - k+5: COLLECT (or DONE), locks cleared.
- Minimum round turnaround is 5 cycles. New strobes are accepted at edge k+6 onward.
- `p1_move`/`p2_move` are stable from lock until the WAIT_REL exit edge, including the whole time `start` = 1.
- `invalid_round` is high exactly one cycle, the cycle after capture.
- Asynchronous `reset` mid-round forces all outputs to reset values immediately. `start` drops, which lets the judge return to IDLE.

## Test plan
- Judge model connected. P1 = 00, P2 = 10, strobed together -> `start` high one window, `p1_score` = 1, `round_cnt` = 1, back in COLLECT at k+5.
- P1 strobes 01 then 10, then P2 strobes 01 -> move 01 kept; tie; scores 0/0, `round_cnt` = 1.
- P1 = 11, P2 = 00 -> `invalid_round` one-cycle pulse, `round_cnt` stays 0, scores unchanged.
- Three P2 wins (P1 = 00, P2 = 01) -> `p2_score` = 3, `match_over` = 1, `match_winner` = 10, DONE; strobes ignored; `new_match` -> all 0, COLLECT.
- Judge model held in IDLE -> after 15 cycles in REQ: `judge_err` = 1, `start` = 0, locks cleared, scores unchanged.
- Assert `reset` while `start` = 1 -> all outputs 0 in the same cycle; judge reaches IDLE; a fresh round then completes normally.
